wb_bfm_burst_master: RTL and testbench
======================================

Name: wb_bfm_burst_master

Overview:
- Synthesizable Wishbone B3 burst master for bus-fabric test harnesses.
- Accepts one command at a time: read or write, start address, length 1..MAX_BURST_LENGTH and burst type.
- Drives classic, incrementing, wrapping or constant-address bursts. Writes come from a flat data bus; read beats are returned on a flat data bus.
- Sits between a stimulus/scoreboard layer and the interconnect under test.

Parameters:
- aw, 32, address width in bits (byte address).
- dw, 32, data width in bits; sel is fixed at 4 bits (32-bit words, 4 bytes per beat).
- MAX_BURST_LENGTH, 5, maximum beats per command.

Ports:
- wb_clk_i  in  1  clock
- wb_rst_i  in  1  reset; synchronous, active-high
- cmd_valid_i  in  1  command request
- cmd_ready_o  out  1  high when idle and able to accept a command
- cmd_we_i  in  1  1 = write burst, 0 = read burst
- cmd_adr_i  in  aw  start byte address; bits [1:0] ignored (forced 0)
- cmd_sel_i  in  4  byte select used on every beat
- cmd_len_i  in  $clog2(MAX_BURST_LENGTH+1)  beat count
- cmd_type_i  in  3  burst type: 0 linear, 1 wrap4, 2 wrap8, 3 wrap16, 4 constant
- cmd_wdata_i  in  dw*MAX_BURST_LENGTH  beat k occupies bits [dw*k +: dw]
- wb_adr_o  out  aw  address
- wb_dat_o  out  dw  write data
- wb_sel_o  out  4  byte select
- wb_we_o  out  1  write enable
- wb_cyc_o  out  1  cycle
- wb_stb_o  out  1  strobe
- wb_cti_o  out  3  cycle type identifier
- wb_bte_o  out  2  burst type extension
- wb_dat_i  in  dw  read data
- wb_ack_i  in  1  acknowledge
- wb_err_i  in  1  error termination
- wb_rty_i  in  1  retry termination
- rdata_o  out  dw*MAX_BURST_LENGTH  captured read beats, same layout as cmd_wdata_i
- done_o  out  1  one-cycle completion pulse
- err_o  out  1  error status of the last command, valid while done_o is high

Behaviour:
- Reset: all outputs 0; rdata_o 0; state IDLE; cmd_ready_o=1 only after reset releases.
- Reset asserted mid-burst aborts at once: cyc/stb drop on the next edge, no done pulse.
- Command fields are registered when cmd_valid_i && cmd_ready_o (IDLE only).
  - cmd_len_i 0 is treated as 1; values above MAX_BURST_LENGTH are clamped to MAX_BURST_LENGTH.
  - cmd_type_i 5..7 starts no bus cycle; the next cycle gives done_o=1, err_o=1.
- States: IDLE -> BUS -> DONE -> IDLE.
  - BUS is entered the cycle after acceptance; cyc, stb, we, sel, adr, dat, cti and bte are all registered.
  - DONE lasts one cycle: done_o=1, cyc=stb=0.
- Beat handshake: the beat completes on the rising edge where stb && (ack||err||rty).
  - On ack with more beats remaining: the next beat's address, data and cti are presented the following cycle. stb stays high, so zero-wait slaves give one beat per clock.
  - On read ack: wb_dat_i is stored into rdata_o slot k for beat k.
  - On ack of the last beat: go to DONE with err_o=0.
  - On err or rty at any beat: terminate the burst, go to DONE with err_o=1. Slots not yet read keep their prior values.
  - If ack and err arrive together, err wins.
- Address sequence. A = word address = adr>>2; output byte address = word<<2.
  - Linear: A, A+1, ...
  - Constant: A on every beat.
  - WrapN: the low log2(N) bits increment modulo N, the upper bits are held. The sequence continues wrapping when len > N; e.g. wrap4 len 5 from word 2 gives 2,3,0,1,2.
- CTI:
  - len 1: 000 (classic).
  - Otherwise intermediate beats are 010 (incrementing or wrap) or 001 (constant), and the last beat is 111.
- BTE: linear 00, wrap4 01, wrap8 10, wrap16 11, constant 00. Held constant for the whole burst.
- wb_we_o is held for the whole burst. wb_dat_o is the write beat k while writing and 0 while reading.
- wb_sel_o = cmd_sel during BUS, 0 otherwise.
- cmd_ready_o is 1 only in IDLE.

Decomposition:
- Package wb_bfm_pkg holds:
  - burst type constants LINEAR_BURST=0, WRAP_4_BURST=1, WRAP_8_BURST=2, WRAP_16_BURST=3, CONSTANT_BURST=4;
  - CTI constants CTI_CLASSIC=000, CTI_CONST=001, CTI_INC=010, CTI_EOB=111;
  - state encoding.
- One sub-module, wb_bfm_adr_gen: combinational next-word-address from the current address and burst type, plus the BTE mapping.

Test Plan:
- Write linear, adr 0x100, len 3, data 11,22,33, ack every cycle -> adr 100,104,108; cti 010,010,111; bte 00; done one cycle after the last ack, err 0.
- Read wrap4, adr 0x1008, len 5 -> adr 1008,100C,1000,1004,1008; bte 01; rdata slots match memory, i.e. the write-then-read pattern returns beat0 == beat4 data.
- Constant, adr 0x20, len 3 -> adr 20,20,20; cti 001,001,111; bte 00.
- Len 1 read at 0x40 with 2 wait states -> cti 000; stb held 3 cycles; rdata slot0 = wb_dat_i at ack.
- Err on beat 2 of a linear len 4 write -> cyc drops, done with err_o=1, only 2 beats issued. Same check with rty instead of err.
- Reset asserted during beat 1 -> cyc/stb 0 next cycle, no done, cmd_ready_o 1 after release.

Source files
------------

// File: rtl/wb_bfm_pkg.sv
// Shared constants for the Wishbone B3 burst master: burst type codes,
// cycle type identifiers, FSM state encoding and the per-beat CTI rule.
package wb_bfm_pkg;

   // Burst type codes as carried on cmd_type_i; codes above CONSTANT_BURST are illegal.
   localparam logic [2:0] LINEAR_BURST   = 3'd0;
   localparam logic [2:0] WRAP_4_BURST   = 3'd1;
   localparam logic [2:0] WRAP_8_BURST   = 3'd2;
   localparam logic [2:0] WRAP_16_BURST  = 3'd3;
   localparam logic [2:0] CONSTANT_BURST = 3'd4;

   // Wishbone cycle type identifiers
   localparam logic [2:0] CTI_CLASSIC = 3'b000;
   localparam logic [2:0] CTI_CONST   = 3'b001;
   localparam logic [2:0] CTI_INC     = 3'b010;
   localparam logic [2:0] CTI_EOB     = 3'b111;

   // FSM states
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUS  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   // CTI for one beat: a single-beat command is a classic cycle, the last
   // beat of a longer burst ends it, everything else announces more beats.
   function automatic logic [2:0] beat_cti(input logic       last,
                                           input logic       single,
                                           input logic [2:0] btype);
      if (single)                  return CTI_CLASSIC;
      if (last)                    return CTI_EOB;
      if (btype == CONSTANT_BURST) return CTI_CONST;
      return CTI_INC;
   endfunction

endpackage

// File: rtl/wb_bfm_adr_gen.sv
// Next-word-address generator and BTE mapping for the burst master.
// Ports:
//   cur_word   - current word address (byte address >> 2)
//   burst_type - burst type code
//   next_word  - word address of the following beat
//   bte        - burst type extension for this burst type
module wb_bfm_adr_gen
   import wb_bfm_pkg::*;
#(
   parameter int WW = 30
) (
   input  logic [WW-1:0] cur_word,
   input  logic [2:0]    burst_type,
   output logic [WW-1:0] next_word,
   output logic [1:0]    bte
);

   logic [WW-1:0] incr;
   logic [WW-1:0] mask;

   assign incr = cur_word + WW'(1);

   always_comb begin
      mask = '0;
      bte  = 2'b00;
      case (burst_type)
         WRAP_4_BURST:  begin mask = WW'(3);  bte = 2'b01; end
         WRAP_8_BURST:  begin mask = WW'(7);  bte = 2'b10; end
         WRAP_16_BURST: begin mask = WW'(15); bte = 2'b11; end
         default: ;
      endcase
      // Wrapping bursts only advance the low bits; the upper bits stay put.
      if (burst_type == CONSTANT_BURST)
         next_word = cur_word;
      else if (mask != '0)
         next_word = (cur_word & ~mask) | (incr & mask);
      else
         next_word = incr;
   end

endmodule

// File: rtl/wb_bfm_burst_master.sv
// Wishbone B3 burst master for bus-fabric test harnesses. Takes one command
// at a time (read/write, start address, length, burst type) and drives a
// classic, incrementing, wrapping or constant-address burst.
// Ports:
//   wb_clk_i, wb_rst_i         - clock, synchronous active-high reset
//   cmd_*                      - command handshake and fields (cmd_ready_o high in IDLE)
//   cmd_wdata_i                - write beats, beat k at [dw*k +: dw]
//   wb_*_o / wb_*_i            - Wishbone master interface, all outputs registered
//   rdata_o                    - captured read beats, same layout as cmd_wdata_i
//   done_o, err_o              - one-cycle completion pulse and its error status
module wb_bfm_burst_master
   import wb_bfm_pkg::*;
#(
   parameter int aw               = 32,
   parameter int dw               = 32,
   parameter int MAX_BURST_LENGTH = 5
) (
   input  logic                                 wb_clk_i,
   input  logic                                 wb_rst_i,
   input  logic                                 cmd_valid_i,
   output logic                                 cmd_ready_o,
   input  logic                                 cmd_we_i,
   input  logic [aw-1:0]                        cmd_adr_i,
   input  logic [3:0]                           cmd_sel_i,
   input  logic [$clog2(MAX_BURST_LENGTH+1)-1:0] cmd_len_i,
   input  logic [2:0]                           cmd_type_i,
   input  logic [dw*MAX_BURST_LENGTH-1:0]       cmd_wdata_i,
   output logic [aw-1:0]                        wb_adr_o,
   output logic [dw-1:0]                        wb_dat_o,
   output logic [3:0]                           wb_sel_o,
   output logic                                 wb_we_o,
   output logic                                 wb_cyc_o,
   output logic                                 wb_stb_o,
   output logic [2:0]                           wb_cti_o,
   output logic [1:0]                           wb_bte_o,
   input  logic [dw-1:0]                        wb_dat_i,
   input  logic                                 wb_ack_i,
   input  logic                                 wb_err_i,
   input  logic                                 wb_rty_i,
   output logic [dw*MAX_BURST_LENGTH-1:0]       rdata_o,
   output logic                                 done_o,
   output logic                                 err_o
);

   localparam int LW = $clog2(MAX_BURST_LENGTH+1);
   localparam int WW = aw - 2;

   logic [1:0]                     state;
   logic [2:0]                     btype;
   logic [LW-1:0]                  len;
   logic [LW-1:0]                  beat;
   logic [LW-1:0]                  nbeat;
   logic [LW-1:0]                  len_eff;
   logic [dw*MAX_BURST_LENGTH-1:0] wdata;
   logic                           err_q;
   logic                           accept;
   logic                           hs;
   logic                           term;
   logic                           last;
   logic [2:0]                     gen_type;
   logic [WW-1:0]                  next_word;
   logic [1:0]                     bte_sel;
   logic                           unused_adr_bits;

   // Byte offset within the word is ignored.
   assign unused_adr_bits = ^cmd_adr_i[1:0];

   assign cmd_ready_o = (state == ST_IDLE) && !wb_rst_i;
   assign accept      = cmd_valid_i && cmd_ready_o;
   assign done_o      = (state == ST_DONE);
   assign err_o       = err_q;

   assign hs    = (state == ST_BUS) && wb_stb_o && (wb_ack_i || wb_err_i || wb_rty_i);
   assign term  = wb_err_i || wb_rty_i;   // err/rty win over a simultaneous ack
   assign last  = (beat == len - LW'(1));
   assign nbeat = beat + LW'(1);

   // In IDLE the generator sees the incoming type so its BTE can be registered
   // at acceptance; during the burst it follows the latched type.
   assign gen_type = (state == ST_IDLE) ? cmd_type_i : btype;

   wb_bfm_adr_gen #(.WW(WW)) u_adr_gen (
      .cur_word   (wb_adr_o[aw-1:2]),
      .burst_type (gen_type),
      .next_word  (next_word),
      .bte        (bte_sel)
   );

   always_comb begin
      len_eff = cmd_len_i;
      if (cmd_len_i == '0)
         len_eff = LW'(1);
      else if (cmd_len_i > LW'(MAX_BURST_LENGTH))
         len_eff = LW'(MAX_BURST_LENGTH);
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state    <= ST_IDLE;
         btype    <= '0;
         len      <= '0;
         beat     <= '0;
         wdata    <= '0;
         err_q    <= 1'b0;
         rdata_o  <= '0;
         wb_cyc_o <= 1'b0;
         wb_stb_o <= 1'b0;
         wb_we_o  <= 1'b0;
         wb_sel_o <= '0;
         wb_adr_o <= '0;
         wb_dat_o <= '0;
         wb_cti_o <= '0;
         wb_bte_o <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  err_q <= 1'b0;
                  if (cmd_type_i > CONSTANT_BURST) begin
                     // Illegal burst type: report an error without touching the bus.
                     err_q <= 1'b1;
                     state <= ST_DONE;
                  end else begin
                     btype    <= cmd_type_i;
                     len      <= len_eff;
                     beat     <= '0;
                     wdata    <= cmd_wdata_i;
                     wb_cyc_o <= 1'b1;
                     wb_stb_o <= 1'b1;
                     wb_we_o  <= cmd_we_i;
                     wb_sel_o <= cmd_sel_i;
                     wb_adr_o <= {cmd_adr_i[aw-1:2], 2'b00};
                     wb_dat_o <= cmd_we_i ? cmd_wdata_i[dw-1:0] : '0;
                     wb_cti_o <= beat_cti(len_eff == LW'(1), len_eff == LW'(1), cmd_type_i);
                     wb_bte_o <= bte_sel;
                     state    <= ST_BUS;
                  end
               end
            end
            ST_BUS: begin
               if (hs) begin
                  if (wb_ack_i && !term && !wb_we_o)
                     rdata_o[dw*int'(beat) +: dw] <= wb_dat_i;
                  if (term || last) begin
                     wb_cyc_o <= 1'b0;
                     wb_stb_o <= 1'b0;
                     wb_we_o  <= 1'b0;
                     wb_sel_o <= '0;
                     wb_adr_o <= '0;
                     wb_dat_o <= '0;
                     wb_cti_o <= '0;
                     wb_bte_o <= '0;
                     err_q    <= term;
                     state    <= ST_DONE;
                  end else begin
                     // stb stays high so a zero-wait slave gets one beat per clock.
                     beat     <= nbeat;
                     wb_adr_o <= {next_word, 2'b00};
                     wb_dat_o <= wb_we_o ? wdata[dw*int'(nbeat) +: dw] : '0;
                     wb_cti_o <= beat_cti(nbeat == len - LW'(1), 1'b0, btype);
                  end
               end
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_wb_bfm_burst_master.sv
// Bench for wb_bfm_burst_master: a memory-backed slave with configurable
// wait states and error/retry injection, directed scenarios and a randomized
// run checked against an address/CTI/data model computed from burst rules.
module tb_wb_bfm_burst_master;

   localparam int MB = 5;

   logic         clk = 1'b0;
   logic         rst;
   logic         cmd_valid, cmd_ready, cmd_we;
   logic [31:0]  cmd_adr;
   logic [3:0]   cmd_sel;
   logic [2:0]   cmd_len, cmd_type;
   logic [159:0] cmd_wdata;
   logic [31:0]  wb_adr, wb_dat_o, wb_dat_i;
   logic [3:0]   wb_sel;
   logic         wb_we, wb_cyc, wb_stb, wb_ack, wb_err, wb_rty;
   logic [2:0]   wb_cti;
   logic [1:0]   wb_bte;
   logic [159:0] rdata;
   logic         done, err;

   always #5 clk = ~clk;

   wb_bfm_burst_master #(.aw(32), .dw(32), .MAX_BURST_LENGTH(MB)) dut (
      .wb_clk_i(clk), .wb_rst_i(rst),
      .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
      .cmd_adr_i(cmd_adr), .cmd_sel_i(cmd_sel), .cmd_len_i(cmd_len),
      .cmd_type_i(cmd_type), .cmd_wdata_i(cmd_wdata),
      .wb_adr_o(wb_adr), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel), .wb_we_o(wb_we),
      .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb), .wb_cti_o(wb_cti), .wb_bte_o(wb_bte),
      .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack), .wb_err_i(wb_err), .wb_rty_i(wb_rty),
      .rdata_o(rdata), .done_o(done), .err_o(err)
   );

   int total = 0;
   int bad   = 0;
   int cyc_n = 0;
   always @(posedge clk) cyc_n <= cyc_n + 1;

   // slave state and observation log
   logic [31:0] mem [1024];
   int cfg_waits = 0, cfg_err_beat = -1, cfg_rty = 0, cfg_both = 0;
   int slv_beat = 0, stb_cnt = 0, hs_cyc = -1, wcnt = 0;
   logic [31:0] q_adr[$], q_dat[$];
   logic [2:0]  q_cti[$];
   logic [1:0]  q_bte[$];
   logic        q_we[$];
   logic [3:0]  q_sel[$];

   // per-command results
   int   acc_cyc, done_cyc;
   logic got_done, done_err, cyc_at_done, pulse_after;

   // Slave: decides each cycle's response at the falling edge; a response
   // here means the beat completes at the next rising edge.
   initial begin
      wb_ack = 0; wb_err = 0; wb_rty = 0; wb_dat_i = 0;
      forever begin
         @(negedge clk);
         wb_ack = 0; wb_err = 0; wb_rty = 0; wb_dat_i = 0;
         if (!rst && wb_cyc && wb_stb) begin
            stb_cnt++;
            if (wcnt < cfg_waits) wcnt++;
            else begin
               wcnt = 0;
               q_adr.push_back(wb_adr); q_dat.push_back(wb_dat_o); q_cti.push_back(wb_cti);
               q_bte.push_back(wb_bte); q_we.push_back(wb_we); q_sel.push_back(wb_sel);
               hs_cyc = cyc_n + 1;
               if (slv_beat == cfg_err_beat) begin
                  if (cfg_rty != 0) wb_rty = 1; else wb_err = 1;
                  if (cfg_both != 0) begin wb_ack = 1; wb_dat_i = 32'hDEADBEEF; end
               end else begin
                  wb_ack = 1;
                  if (wb_we) mem[wb_adr[11:2]] = wb_dat_o;
                  else wb_dat_i = mem[wb_adr[11:2]];
               end
               slv_beat++;
            end
         end else wcnt = 0;
      end
   end

   // Model: byte address of beat i for a burst starting at adr.
   function automatic logic [31:0] exp_adr(input logic [31:0] adr, input logic [2:0] typ, input int i);
      int unsigned a, n, base;
      a = adr >> 2;
      case (typ)
         3'd1: n = 4;
         3'd2: n = 8;
         3'd3: n = 16;
         default: n = 0;
      endcase
      if (typ == 3'd4) return a << 2;
      if (n == 0) return (a + int'(i)) << 2;
      base = a - (a % n);
      return (base + (a % n + i) % n) << 2;
   endfunction

   task automatic clear_log();
      q_adr.delete(); q_dat.delete(); q_cti.delete(); q_bte.delete(); q_we.delete(); q_sel.delete();
      slv_beat = 0; stb_cnt = 0; hs_cyc = -1;
   endtask

   task automatic issue_cmd(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                            input logic [2:0] len, input logic [2:0] typ, input logic [159:0] wd,
                            input int waits, input int eb, input int rty, input int both);
      clear_log();
      cfg_waits = waits; cfg_err_beat = eb; cfg_rty = rty; cfg_both = both;
      got_done = 0; done_err = 0; cyc_at_done = 0; done_cyc = -1;
      @(negedge clk);
      cmd_valid = 1; cmd_we = we; cmd_adr = adr; cmd_sel = sel;
      cmd_len = len; cmd_type = typ; cmd_wdata = wd;
      @(negedge clk);
      cmd_valid = 0; acc_cyc = cyc_n;
      for (int i = 0; i < 200; i++) begin
         if (done) begin
            got_done = 1; done_cyc = cyc_n; done_err = err; cyc_at_done = wb_cyc;
            break;
         end
         @(negedge clk);
      end
      total++;
      if (!got_done) begin bad++; $display("FAIL done_timeout: got no done in 200 cycles, want done"); end
      @(negedge clk);
      pulse_after = done;
      cfg_err_beat = -1; cfg_waits = 0;
   endtask

   task automatic test_reset();
      rst = 1; cmd_valid = 0; cmd_we = 0; cmd_adr = 0; cmd_sel = 0;
      cmd_len = 0; cmd_type = 0; cmd_wdata = 0;
      repeat (3) @(negedge clk);
      total++;
      if ({wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_o, wb_sel, wb_cti, wb_bte, done, err} !== '0) begin
         bad++; $display("FAIL reset_outputs: got cyc=%b stb=%b adr=%h done=%b err=%b, want all 0",
                         wb_cyc, wb_stb, wb_adr, done, err);
      end
      total++; if (rdata !== '0) begin bad++; $display("FAIL reset_rdata: got %h want 0", rdata); end
      total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL reset_ready_in_rst: got %b want 0", cmd_ready); end
      rst = 0;
      @(negedge clk);
      total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_ready_after: got %b want 1", cmd_ready); end
   endtask

   task automatic test_linear_write();
      logic [159:0] wd;
      logic [31:0] ea [3] = '{32'h100, 32'h104, 32'h108};
      logic [2:0]  ec [3] = '{3'b010, 3'b010, 3'b111};
      logic [31:0] ed [3] = '{32'h11, 32'h22, 32'h33};
      wd = '0; wd[31:0] = 32'h11; wd[63:32] = 32'h22; wd[95:64] = 32'h33;
      issue_cmd(1, 32'h100, 4'hF, 3'd3, 3'd0, wd, 0, -1, 0, 0);
      total++; if (q_adr.size() != 3) begin bad++; $display("FAIL lin_beats: got %0d want 3", q_adr.size()); end
      for (int i = 0; i < 3 && i < q_adr.size(); i++) begin
         total++;
         if (q_adr[i] !== ea[i] || q_cti[i] !== ec[i] || q_bte[i] !== 2'b00 || q_dat[i] !== ed[i] || q_we[i] !== 1'b1) begin
            bad++; $display("FAIL lin_beat%0d: got adr=%h cti=%b bte=%b dat=%h we=%b want adr=%h cti=%b bte=00 dat=%h we=1",
                            i, q_adr[i], q_cti[i], q_bte[i], q_dat[i], q_we[i], ea[i], ec[i], ed[i]);
         end
      end
      total++; if (done_err !== 1'b0) begin bad++; $display("FAIL lin_err: got %b want 0", done_err); end
      total++; if (done_cyc != hs_cyc) begin bad++; $display("FAIL lin_done_time: got cycle %0d want %0d", done_cyc, hs_cyc); end
      total++; if (pulse_after !== 1'b0) begin bad++; $display("FAIL lin_done_pulse: got %b want 0", pulse_after); end
   endtask

   task automatic test_wrap_read();
      logic [159:0] wd, er;
      logic [31:0] ea [5] = '{32'h1008, 32'h100C, 32'h1000, 32'h1004, 32'h1008};
      wd = '0; wd[31:0] = 32'hA0; wd[63:32] = 32'hA1; wd[95:64] = 32'hA2; wd[127:96] = 32'hA3;
      issue_cmd(1, 32'h1000, 4'hF, 3'd4, 3'd0, wd, 0, -1, 0, 0);
      issue_cmd(0, 32'h1008, 4'h5, 3'd5, 3'd1, '0, 0, -1, 0, 0);
      total++; if (q_adr.size() != 5) begin bad++; $display("FAIL wrap_beats: got %0d want 5", q_adr.size()); end
      for (int i = 0; i < 5 && i < q_adr.size(); i++) begin
         total++;
         if (q_adr[i] !== ea[i] || q_bte[i] !== 2'b01 || q_cti[i] !== ((i == 4) ? 3'b111 : 3'b010) || q_sel[i] !== 4'h5) begin
            bad++; $display("FAIL wrap_beat%0d: got adr=%h bte=%b cti=%b sel=%h want adr=%h bte=01", i, q_adr[i], q_bte[i], q_cti[i], q_sel[i], ea[i]);
         end
      end
      er = {32'hA2, 32'hA1, 32'hA0, 32'hA3, 32'hA2};
      total++; if (rdata !== er) begin bad++; $display("FAIL wrap_rdata: got %h want %h", rdata, er); end
   endtask

   task automatic test_constant();
      logic [2:0] ec [3] = '{3'b001, 3'b001, 3'b111};
      issue_cmd(0, 32'h20, 4'hF, 3'd3, 3'd4, '0, 0, -1, 0, 0);
      total++; if (q_adr.size() != 3) begin bad++; $display("FAIL const_beats: got %0d want 3", q_adr.size()); end
      for (int i = 0; i < 3 && i < q_adr.size(); i++) begin
         total++;
         if (q_adr[i] !== 32'h20 || q_cti[i] !== ec[i] || q_bte[i] !== 2'b00) begin
            bad++; $display("FAIL const_beat%0d: got adr=%h cti=%b bte=%b want adr=20 cti=%b bte=00", i, q_adr[i], q_cti[i], q_bte[i], ec[i]);
         end
      end
   endtask

   task automatic test_wait_single();
      mem[16] = 32'hCAFEF00D;
      issue_cmd(0, 32'h40, 4'hF, 3'd1, 3'd0, '0, 2, -1, 0, 0);
      total++; if (q_adr.size() != 1) begin bad++; $display("FAIL single_beats: got %0d want 1", q_adr.size()); end
      if (q_adr.size() > 0) begin
         total++;
         if (q_adr[0] !== 32'h40 || q_cti[0] !== 3'b000) begin
            bad++; $display("FAIL single_beat: got adr=%h cti=%b want adr=40 cti=000", q_adr[0], q_cti[0]);
         end
      end
      total++; if (stb_cnt != 3) begin bad++; $display("FAIL single_stb_cycles: got %0d want 3", stb_cnt); end
      total++; if (rdata[31:0] !== 32'hCAFEF00D) begin bad++; $display("FAIL single_rdata: got %h want cafef00d", rdata[31:0]); end
      total++; if (done_err !== 1'b0) begin bad++; $display("FAIL single_err: got %b want 0", done_err); end
   endtask

   task automatic test_err_rty();
      logic [159:0] wd;
      for (int r = 0; r < 2; r++) begin
         wd = {32'h5, 32'h4, 32'h3, 32'h2, 32'h1};
         issue_cmd(1, 32'h200, 4'hF, 3'd4, 3'd0, wd, 0, 1, r, 0);
         total++; if (q_adr.size() != 2) begin bad++; $display("FAIL term%0d_beats: got %0d want 2", r, q_adr.size()); end
         total++; if (done_err !== 1'b1) begin bad++; $display("FAIL term%0d_err: got %b want 1", r, done_err); end
         total++; if (cyc_at_done !== 1'b0) begin bad++; $display("FAIL term%0d_cyc: got %b want 0", r, cyc_at_done); end
      end
   endtask

   task automatic test_reset_mid();
      int seen;
      clear_log();
      cfg_waits = 1; cfg_err_beat = -1;
      @(negedge clk);
      cmd_valid = 1; cmd_we = 0; cmd_adr = 32'h300; cmd_sel = 4'hF; cmd_len = 3'd4; cmd_type = 3'd0;
      @(negedge clk);
      cmd_valid = 0;
      for (int i = 0; i < 50 && slv_beat < 1; i++) @(negedge clk);
      total++; if (slv_beat < 1) begin bad++; $display("FAIL rstmid_timeout: got %0d beats want 1", slv_beat); end
      @(negedge clk);
      rst = 1;
      @(negedge clk);
      total++; if (wb_cyc !== 1'b0 || wb_stb !== 1'b0 || done !== 1'b0) begin
         bad++; $display("FAIL rstmid_abort: got cyc=%b stb=%b done=%b want 0 0 0", wb_cyc, wb_stb, done);
      end
      total++; if (rdata !== '0) begin bad++; $display("FAIL rstmid_rdata: got %h want 0", rdata); end
      @(negedge clk);
      rst = 0;
      seen = 0;
      repeat (4) begin @(negedge clk); if (done) seen++; end
      total++; if (seen != 0) begin bad++; $display("FAIL rstmid_no_done: got %0d pulses want 0", seen); end
      total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL rstmid_ready: got %b want 1", cmd_ready); end
      cfg_waits = 0;
   endtask

   task automatic test_random();
      logic [31:0] exp_rd [MB];
      logic [159:0] wd, er;
      logic we, badt, hit, eerr;
      logic [31:0] adr, ea, ed, t;
      logic [3:0] sel;
      logic [2:0] len, typ, ec;
      logic [1:0] eb2;
      int waits, eb, r, both, leff, nb, nack;
      for (int k = 0; k < MB; k++) exp_rd[k] = '0;
      for (int n = 0; n < 40; n++) begin
         we = 1'($urandom_range(0, 1)); adr = $urandom; sel = 4'($urandom_range(0, 15));
         len = 3'($urandom_range(0, 7));
         typ = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
         waits = $urandom_range(0, 2);
         eb = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 4) : -1;
         r = $urandom_range(0, 1); both = $urandom_range(0, 1);
         for (int k = 0; k < MB; k++) wd[32*k +: 32] = $urandom;
         issue_cmd(we, adr, sel, len, typ, wd, waits, eb, r, both);

         leff = (len == 0) ? 1 : (len > MB) ? MB : int'(len);
         badt = (typ > 3'd4);
         hit  = (eb >= 0 && eb < leff);
         eerr = badt || hit;
         nb   = badt ? 0 : (hit ? eb + 1 : leff);
         nack = badt ? 0 : (hit ? eb : leff);
         eb2  = (typ >= 3'd1 && typ <= 3'd3) ? typ[1:0] : 2'b00;

         total++; if (done_err !== eerr) begin bad++; $display("FAIL rnd%0d_err: got %b want %b", n, done_err, eerr); end
         total++; if (q_adr.size() != nb) begin bad++; $display("FAIL rnd%0d_beats: got %0d want %0d", n, q_adr.size(), nb); end
         for (int i = 0; i < nb && i < q_adr.size(); i++) begin
            ea = exp_adr(adr, typ, i);
            ec = (leff == 1) ? 3'b000 : (i == leff - 1) ? 3'b111 : (typ == 3'd4) ? 3'b001 : 3'b010;
            ed = we ? wd[32*i +: 32] : 32'h0;
            total++;
            if (q_adr[i] !== ea || q_cti[i] !== ec || q_bte[i] !== eb2 || q_we[i] !== we || q_sel[i] !== sel || q_dat[i] !== ed) begin
               bad++; $display("FAIL rnd%0d_beat%0d: got adr=%h cti=%b bte=%b we=%b sel=%h dat=%h want adr=%h cti=%b bte=%b we=%b sel=%h dat=%h",
                               n, i, q_adr[i], q_cti[i], q_bte[i], q_we[i], q_sel[i], q_dat[i], ea, ec, eb2, we, sel, ed);
            end
         end
         if (!we) for (int i = 0; i < nack; i++) begin
            t = exp_adr(adr, typ, i);
            exp_rd[i] = mem[t[11:2]];
         end
         for (int k = 0; k < MB; k++) er[32*k +: 32] = exp_rd[k];
         total++; if (rdata !== er) begin bad++; $display("FAIL rnd%0d_rdata: got %h want %h", n, rdata, er); end
         total++;
         if (done_cyc != (badt ? acc_cyc : hs_cyc)) begin
            bad++; $display("FAIL rnd%0d_done_time: got cycle %0d want %0d", n, done_cyc, badt ? acc_cyc : hs_cyc);
         end
         total++; if (pulse_after !== 1'b0) begin bad++; $display("FAIL rnd%0d_done_pulse: got %b want 0", n, pulse_after); end
      end
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = $urandom;
      test_reset();
      test_linear_write();
      test_wrap_read();
      test_constant();
      test_wait_single();
      test_err_rty();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
